// File: rtl/video_pkg.sv
// Shared video constants for the sprite engine.
// Contents: default sprite geometry, palette-index width, transparent index,
// button step size, active screen size, and a small clamp helper used when
// loading sprite positions.
package video_pkg;

  localparam int DEF_SCREEN_W    = 800;
  localparam int DEF_SCREEN_H    = 600;
  localparam int DEF_SPRITE_SIZE = 32;
  localparam int DEF_NUM_SPRITES = 4;
  localparam int DEF_IDX_W       = 8;
  localparam int DEF_TRANSPARENT = 0;
  localparam int DEF_STEP        = 4;

  // Saturate a 10-bit coordinate at an upper limit.
  function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sprite_engine_if.sv
// Sprite memory bus between the sprite engine and the external sprite RAM.
// Ports (signals):
//   mem_addr : engine -> memory, registered read address
//   mem_data : memory -> engine, palette index, valid the cycle after mem_addr
// Modports: master (engine side), slave (memory side).
interface sprite_engine_if #(
  parameter int AW    = 12,
  parameter int IDX_W = 8
);
  logic [AW-1:0]    mem_addr;
  logic [IDX_W-1:0] mem_data;

  modport master (output mem_addr, input  mem_data);
  modport slave  (input  mem_addr, output mem_data);
endinterface

// File: rtl/sprite_hit.sv
// Per-sprite position compare.
// Ports:
//   x_i, y_i           : sprite top-left corner
//   en_i               : sprite enable
//   video_enable_i     : active-area flag
//   pixel_x_i/pixel_y_i: current scan position
//   hit_o              : scan position lies inside this sprite
//   off_x_o/off_y_o    : column/row offset of the scan position inside the sprite
module sprite_hit #(
  parameter  int SPRITE_SIZE = 32,
  localparam int OW          = $clog2(SPRITE_SIZE)
) (
  input  logic [9:0]    x_i,
  input  logic [9:0]    y_i,
  input  logic          en_i,
  input  logic          video_enable_i,
  input  logic [10:0]   pixel_x_i,
  input  logic [9:0]    pixel_y_i,
  output logic          hit_o,
  output logic [OW-1:0] off_x_o,
  output logic [OW-1:0] off_y_o
);

  // 12-bit compares so x+SPRITE_SIZE can never wrap past the screen edge.
  logic [11:0] px, py, x0, y0;
  logic        in_x, in_y;

  assign px   = {1'b0, pixel_x_i};
  assign py   = {2'b0, pixel_y_i};
  assign x0   = {2'b0, x_i};
  assign y0   = {2'b0, y_i};
  assign in_x = (px >= x0) && (px < x0 + 12'(SPRITE_SIZE));
  assign in_y = (py >= y0) && (py < y0 + 12'(SPRITE_SIZE));

  assign hit_o   = en_i & video_enable_i & in_x & in_y;
  assign off_x_o = OW'(px - x0);
  assign off_y_o = OW'(py - y0);

endmodule

// File: rtl/sprite_engine.sv
// Hardware sprite overlay: per-pixel sprite hit detection, sprite memory
// addressing and opaque-pixel flagging with a fixed 2-cycle latency.
// Ports:
//   clk, reset            : pixel clock, synchronous active-high reset
//   video_enable          : active-area flag
//   pixel_x, pixel_y      : current scan position
//   frame_start           : frame pulse; samples the move buttons for sprite 0
//   left/right_sprite     : move sprite 0 by STEP pixels on frame_start
//   cfg_we/sel/x/y/en     : sprite position/enable write port
//   mem (master)          : sprite memory read bus (mem_addr/mem_data)
//   pix_idx, pix_valid    : palette index and opaque-sprite-pixel flag
module sprite_engine
  import video_pkg::*;
#(
  parameter  int SPRITE_SIZE = DEF_SPRITE_SIZE,
  parameter  int NUM_SPRITES = DEF_NUM_SPRITES,
  parameter  int IDX_W       = DEF_IDX_W,
  parameter  int TRANSPARENT = DEF_TRANSPARENT,
  parameter  int STEP        = DEF_STEP,
  parameter  int SCREEN_W    = DEF_SCREEN_W,
  parameter  int SCREEN_H    = DEF_SCREEN_H,
  localparam int SEL_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int AW          = $clog2(NUM_SPRITES * SPRITE_SIZE * SPRITE_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             video_enable,
  input  logic [10:0]      pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             frame_start,
  input  logic             left_sprite,
  input  logic             right_sprite,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [9:0]       cfg_x,
  input  logic [9:0]       cfg_y,
  input  logic             cfg_en,
  sprite_engine_if.master  mem,
  output logic [IDX_W-1:0] pix_idx,
  output logic             pix_valid
);

  localparam int         OW     = $clog2(SPRITE_SIZE);
  localparam logic [9:0] X_MAX  = 10'(SCREEN_W - SPRITE_SIZE);
  localparam logic [9:0] Y_MAX  = 10'(SCREEN_H - SPRITE_SIZE);
  localparam logic [9:0] X_RST  = 10'((SCREEN_W - SPRITE_SIZE) / 2);
  localparam logic [9:0] Y_RST  = 10'((SCREEN_H - SPRITE_SIZE) / 2);
  localparam logic [9:0] STEP_V = 10'(STEP);

  logic [9:0] x_q [NUM_SPRITES];
  logic [9:0] x_d [NUM_SPRITES];
  logic [9:0] y_q [NUM_SPRITES];
  logic [9:0] y_d [NUM_SPRITES];
  logic       en_q [NUM_SPRITES];
  logic       en_d [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] hit;
  logic [OW-1:0]          off_x [NUM_SPRITES];
  logic [OW-1:0]          off_y [NUM_SPRITES];

  logic [SEL_W-1:0]      sel;
  logic                  any_hit;
  logic [SEL_W+2*OW-1:0] addr_full;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic                  hit_q;
  logic                  pix_valid_q, pix_valid_d;
  logic [IDX_W-1:0]      pix_idx_q, pix_idx_d;
  logic [10:0]           x0_plus;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit #(.SPRITE_SIZE(SPRITE_SIZE)) u_hit (
      .x_i            (x_q[g]),
      .y_i            (y_q[g]),
      .en_i           (en_q[g]),
      .video_enable_i (video_enable),
      .pixel_x_i      (pixel_x),
      .pixel_y_i      (pixel_y),
      .hit_o          (hit[g]),
      .off_x_o        (off_x[g]),
      .off_y_o        (off_y[g])
    );
  end

  // Sprite registers: button move on frame_start, then cfg write overrides it.
  assign x0_plus = {1'b0, x_q[0]} + 11'(STEP);

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      x_d[i]  = x_q[i];
      y_d[i]  = y_q[i];
      en_d[i] = en_q[i];
    end
    if (frame_start && (left_sprite ^ right_sprite)) begin
      if (left_sprite)
        x_d[0] = (x_q[0] < STEP_V) ? 10'd0 : x_q[0] - STEP_V;
      else
        x_d[0] = (x0_plus > {1'b0, X_MAX}) ? X_MAX : x0_plus[9:0];
    end
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (cfg_we && (int'(cfg_sel) == i)) begin
        x_d[i]  = clamp10(cfg_x, X_MAX);
        y_d[i]  = clamp10(cfg_y, Y_MAX);
        en_d[i] = cfg_en;
      end
    end
  end

  // Lowest-index hit wins; scanning downward lets lower indices overwrite.
  always_comb begin
    sel     = '0;
    any_hit = 1'b0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel     = SEL_W'(i);
        any_hit = 1'b1;
      end
    end
  end

  // Power-of-two sprite size turns sel*S^2 + row*S + col into a concatenation.
  assign addr_full  = {sel, off_y[sel], off_x[sel]};
  assign mem_addr_d = any_hit ? addr_full[AW-1:0] : mem_addr_q;

  assign pix_valid_d = hit_q && (mem.mem_data != IDX_W'(TRANSPARENT));
  assign pix_idx_d   = pix_valid_d ? mem.mem_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]  <= (i == 0) ? X_RST : 10'd0;
        y_q[i]  <= (i == 0) ? Y_RST : 10'd0;
        en_q[i] <= (i == 0);
      end
      mem_addr_q  <= '0;
      hit_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_idx_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
        en_q[i] <= en_d[i];
      end
      // stage 0: address and hit flag
      mem_addr_q  <= mem_addr_d;
      hit_q       <= any_hit;
      // stage 1: returned palette index
      pix_valid_q <= pix_valid_d;
      pix_idx_q   <= pix_idx_d;
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign pix_idx      = pix_idx_q;
  assign pix_valid    = pix_valid_q;

endmodule

// File: tb/tb_sprite_engine.sv
module tb_sprite_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_enable = 1'b0;
  logic [10:0] pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        frame_start = 1'b0;
  logic        left_sprite = 1'b0;
  logic        right_sprite = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [9:0]  cfg_x = '0;
  logic [9:0]  cfg_y = '0;
  logic        cfg_en = 1'b0;
  logic [7:0]  pix_idx;
  logic        pix_valid;

  logic [7:0]  sprite_mem [4096];

  int nvec = 0;
  int nerr = 0;
  bit started = 0;

  // Reference state: sprite positions and expected pipeline outputs.
  int mx [4];
  int my [4];
  bit men [4];
  int m_addr = 0;
  bit m_hit = 0;
  bit m_valid = 0;
  int m_idx = 0;

  sprite_engine_if #(.AW(12), .IDX_W(8)) mif ();

  assign mif.mem_data = sprite_mem[mif.mem_addr];

  sprite_engine dut (
    .clk          (clk),
    .reset        (reset),
    .video_enable (video_enable),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .frame_start  (frame_start),
    .left_sprite  (left_sprite),
    .right_sprite (right_sprite),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_x        (cfg_x),
    .cfg_y        (cfg_y),
    .cfg_en       (cfg_en),
    .mem          (mif),
    .pix_idx      (pix_idx),
    .pix_valid    (pix_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int d, sel, px, py;
    started = 1;
    if (reset) begin
      mx[0] = 384; my[0] = 284; men[0] = 1;
      for (int i = 1; i < 4; i++) begin mx[i] = 0; my[i] = 0; men[i] = 0; end
      m_addr = 0; m_hit = 0; m_valid = 0; m_idx = 0;
    end else begin
      d = int'(sprite_mem[m_addr]);
      m_valid = m_hit && (d != 0);
      m_idx = m_valid ? d : 0;
      px = int'(pixel_x);
      py = int'(pixel_y);
      sel = -1;
      for (int i = 0; i < 4; i++)
        if (sel < 0 && men[i] && video_enable &&
            px >= mx[i] && px < mx[i] + 32 && py >= my[i] && py < my[i] + 32)
          sel = i;
      if (sel >= 0) begin
        m_hit = 1;
        m_addr = sel * 1024 + (py - my[sel]) * 32 + (px - mx[sel]);
      end else begin
        m_hit = 0;
      end
      if (frame_start && left_sprite && !right_sprite)
        mx[0] = (mx[0] - 4 < 0) ? 0 : mx[0] - 4;
      if (frame_start && right_sprite && !left_sprite)
        mx[0] = (mx[0] + 4 > 768) ? 768 : mx[0] + 4;
      if (cfg_we) begin
        mx[cfg_sel] = (int'(cfg_x) > 768) ? 768 : int'(cfg_x);
        my[cfg_sel] = (int'(cfg_y) > 568) ? 568 : int'(cfg_y);
        men[cfg_sel] = cfg_en;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_addr", int'(mif.mem_addr), m_addr);
      check("cyc_valid", int'(pix_valid), int'(m_valid));
      check("cyc_idx", int'(pix_idx), m_idx);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int px, input int py);
    pixel_x = 11'(px);
    pixel_y = 10'(py);
    tick();
    tick();
  endtask

  task automatic cfg(input int sel, input int x, input int y, input bit en);
    cfg_we = 1; cfg_sel = 2'(sel); cfg_x = 10'(x); cfg_y = 10'(y); cfg_en = en;
    tick();
    cfg_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 4096; a++) sprite_mem[a] = 8'((a % 255) + 1);
    sprite_mem[528] = 8'h05;
    sprite_mem[0]   = 8'h00;

    // reset state
    tick(); tick();
    check("rst_addr", int'(mif.mem_addr), 0);
    check("rst_valid", int'(pix_valid), 0);
    check("rst_idx", int'(pix_idx), 0);
    check("model_rst_x0", mx[0], 384);

    // first pixel at screen centre
    reset = 0; video_enable = 1;
    pixel_x = 400; pixel_y = 300;
    tick();
    check("centre_addr", int'(mif.mem_addr), 528);
    tick();
    check("centre_idx", int'(pix_idx), 5);
    check("centre_valid", int'(pix_valid), 1);

    // right edge inclusive/exclusive, address held on miss
    pixel_x = 415; pixel_y = 284;
    tick();
    pixel_x = 416;
    tick();
    check("edge415_valid", int'(pix_valid), 1);
    tick();
    check("edge416_valid", int'(pix_valid), 0);
    check("edge416_addr_held", int'(mif.mem_addr), 31);

    // overlapping sprites: transparent winner does not fall through
    cfg(0, 100, 100, 1);
    cfg(1, 100, 100, 1);
    probe(100, 100);
    check("overlap_valid", int'(pix_valid), 0);
    check("overlap_idx", int'(pix_idx), 0);
    check("overlap_addr", int'(mif.mem_addr), 0);
    probe(101, 100);
    check("overlap_opaque_addr", int'(mif.mem_addr), 1);
    video_enable = 0;
    probe(101, 100);
    check("blank_valid", int'(pix_valid), 0);
    video_enable = 1;
    cfg(0, 100, 100, 0);
    probe(100, 100);
    check("spr1_addr", int'(mif.mem_addr), 1024);
    check("spr1_idx", int'(pix_idx), 5);
    cfg(0, 100, 100, 1);

    // cfg clamping
    cfg(2, 1000, 1000, 1);
    probe(768, 568);
    check("clamp_addr", int'(mif.mem_addr), 2048);
    check("clamp_idx", int'(pix_idx), 9);
    probe(799, 599);
    check("corner_addr", int'(mif.mem_addr), 3071);
    check("corner_idx", int'(pix_idx), 12);
    probe(767, 568);
    check("clamp_left_miss", int'(pix_valid), 0);

    // button movement, saturating at both ends
    cfg(0, 2, 100, 1);
    frame_start = 1; left_sprite = 1;
    tick();
    frame_start = 0;
    tick(); tick();
    left_sprite = 0;
    check("model_left_sat", mx[0], 0);
    probe(0, 101);
    check("left_sat_addr", int'(mif.mem_addr), 32);
    check("left_sat_valid", int'(pix_valid), 1);

    cfg(0, 766, 100, 1);
    frame_start = 1; right_sprite = 1;
    tick();
    frame_start = 0; right_sprite = 0;
    check("model_right_sat", mx[0], 768);
    probe(768, 101);
    check("right_sat_valid", int'(pix_valid), 1);
    probe(767, 101);
    check("right_sat_miss", int'(pix_valid), 0);

    frame_start = 1; left_sprite = 1; right_sprite = 1;
    tick();
    frame_start = 0; left_sprite = 0; right_sprite = 0;
    check("model_both", mx[0], 768);
    probe(767, 101);
    check("both_miss", int'(pix_valid), 0);

    frame_start = 1; left_sprite = 1;
    tick();
    frame_start = 0; left_sprite = 0;
    check("model_step_left", mx[0], 764);
    probe(764, 101);
    check("step_left_valid", int'(pix_valid), 1);

    // cfg write beats a simultaneous move
    cfg_we = 1; cfg_sel = 0; cfg_x = 50; cfg_y = 100; cfg_en = 1;
    frame_start = 1; right_sprite = 1;
    tick();
    cfg_we = 0; frame_start = 0; right_sprite = 0;
    check("model_cfg_wins", mx[0], 50);
    probe(50, 101);
    check("cfg_wins_addr", int'(mif.mem_addr), 32);
    check("cfg_wins_valid", int'(pix_valid), 1);

    // reset during an active hit
    cfg(0, 390, 290, 1);
    probe(400, 300);
    check("pre_rst_valid", int'(pix_valid), 1);
    check("pre_rst_addr", int'(mif.mem_addr), 330);
    reset = 1;
    tick();
    reset = 0;
    check("post_rst0_valid", int'(pix_valid), 0);
    tick();
    check("post_rst1_valid", int'(pix_valid), 0);
    tick();
    check("post_rst2_valid", int'(pix_valid), 1);
    check("post_rst2_idx", int'(pix_idx), 5);
    check("model_post_rst_x0", mx[0], 384);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 The block SHALL take parameter SPRITE_SIZE, default 32, meaning the sprite edge length in pixels (power of two, 8..64).
REQ-002 The block SHALL take parameter NUM_SPRITES, default 4, meaning the number of independent sprites (1..8).
REQ-003 The block SHALL take parameter IDX_W, default 8, meaning the palette-index width of the sprite memory data.
REQ-004 The block SHALL take parameter TRANSPARENT, default 0, meaning the palette index treated as transparent.
REQ-005 The block SHALL take parameter STEP, default 4, meaning the pixels moved per frame by button movement.
REQ-006 The block SHALL take parameters SCREEN_W, default 800, and SCREEN_H, default 600, meaning the active area size.
REQ-007 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-008 Ports SHALL be as follows:
- clk  in  1  pixel clock.
- reset  in  1  synchronous active-high reset.
- video_enable  in  1  active-area flag.
- pixel_x  in  11  current column.
- pixel_y  in  10  current row.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- left_sprite  in  1  level; move sprite 0 left.
- right_sprite  in  1  level; move sprite 0 right.
- cfg_we  in  1  position/enable write strobe.
- cfg_sel  in  clog2(NUM_SPRITES)  target sprite.
- cfg_x  in  10  new x.
- cfg_y  in  10  new y.
- cfg_en  in  1  new enable.
- mem_addr  out  AW=clog2(NUM_SPRITES*SPRITE_SIZE^2)  sprite memory address.
- mem_data  in  IDX_W  sprite memory data, valid one cycle after mem_addr.
- pix_idx  out  IDX_W  palette index.
- pix_valid  out  1  pix_idx is an opaque sprite pixel.

Function
REQ-009 Each sprite i SHALL hold registers x_i (10 b), y_i (10 b), and en_i.
REQ-010 Sprite i SHALL hit when en_i=1 and video_enable=1 and x_i <= pixel_x < x_i+SPRITE_SIZE and y_i <= pixel_y < y_i+SPRITE_SIZE; bounds are inclusive/exclusive exactly as written, and comparisons use at least 11 bits so there is no wrap.
REQ-011 If several sprites hit, the lowest index SHALL win; sprites with a higher index are not consulted even if the winner's pixel is transparent.
REQ-012 Stage 0 (registered) SHALL drive mem_addr = sel*SPRITE_SIZE^2 + (pixel_y-y_sel)*SPRITE_SIZE + (pixel_x-x_sel) and a registered hit flag.
REQ-013 With no hit, mem_addr SHALL hold its previous value and the hit flag SHALL be 0.
REQ-014 Stage 1 SHALL register pix_idx = mem_data and pix_valid = hit & (mem_data != TRANSPARENT), giving a fixed 2-cycle latency from pixel_x/pixel_y to pix_idx/pix_valid.
REQ-015 When pix_valid=0, pix_idx SHALL be 0.
REQ-016 On frame_start, sprite 0 SHALL set x_0 to max(x_0-STEP, 0) if only left_sprite=1, and to min(x_0+STEP, SCREEN_W-SPRITE_SIZE) if only right_sprite=1; if both or neither are 1, x_0 SHALL be unchanged.
REQ-017 Outside frame_start cycles, the button inputs SHALL be ignored.
REQ-018 cfg_we SHALL load x, y, and en of sprite cfg_sel in the next cycle; cfg_x is clamped to SCREEN_W-SPRITE_SIZE and cfg_y is clamped to SCREEN_H-SPRITE_SIZE.
REQ-019 If cfg_we targets sprite 0 in the same cycle as a frame_start move, the cfg write SHALL win.
REQ-020 Position changes SHALL take effect on the pixel compare in the cycle after the register update; mid-frame writes are permitted, and tearing is acceptable.

Reset
REQ-021 On reset, x_0 SHALL be (SCREEN_W-SPRITE_SIZE)/2, y_0 SHALL be (SCREEN_H-SPRITE_SIZE)/2, and en_0 SHALL be 1.
REQ-022 On reset, all other sprites SHALL be at (0,0) with en=0.
REQ-023 On reset, mem_addr, pix_idx, pix_valid, and the pipeline hit flags SHALL be 0.
REQ-024 Reset asserted mid-line SHALL clear the pipeline, so that pix_valid=0 for the 2 cycles following deassertion regardless of input.

Structure
REQ-025 Default parameters, TRANSPARENT, and the screen-size constants SHALL live in a shared package, video_pkg.
REQ-026 A sub-module sprite_hit (one per sprite: position compare plus local row/column offsets) SHALL be instantiated NUM_SPRITES times.
REQ-027 Sprite memory and palette lookup SHALL stay outside the block.

Verification
REQ-028 Reset, then scan pixel (400,300) with mem_data=0x05 -> mem_addr = 16*32+16 = 528 after 1 cycle; pix_idx=0x05 and pix_valid=1 after 2 cycles.
REQ-029 Sprite 0 at (384,284), scan x=415 then x=416 on row 284 -> pix_valid=1 for 415 and pix_valid=0 for 416.
REQ-030 Sprites 0 and 1 both enabled at (100,100), with sprite 0's pixel = TRANSPARENT -> pix_valid=0 (no fall-through to sprite 1).
REQ-031 x_0=2, left_sprite=1, frame_start pulse -> x_0=0; x_0=766, right_sprite=1 -> x_0=768; both buttons held -> x_0 unchanged.
REQ-032 cfg_we with sel=0 and x=50 in the same cycle as frame_start with right_sprite=1 -> x_0=50.
REQ-033 Assert reset during an active sprite hit -> pix_valid=0 for 2 cycles after deassertion, and x_0 returns to 384.
